tt_um_processor: RTL and testbench

// - TinyTapeout-wrapped 4-bit-operand / 8-bit-accumulator processor slice.
// - Each enabled clock executes one opcode on operands from the input pins and

---
 rtl/tt_um_processor_pkg.sv | 32 +++
 rtl/tt_um_processor_alu.sv | 78 +++++++
 rtl/tt_um_processor.sv | 59 +++++
 tb/tb_tt_um_processor.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/tt_um_processor_pkg.sv
// rtl/tt_um_processor_pkg.sv - opcode, flag and width definitions for the accumulator processor
package tt_um_processor_pkg;

   localparam int ACC_W = 8;
   localparam int OPD_W = 4;

   // Index of each flag within the 4-bit flag nibble (C is the MSB on the pins).
   localparam int FLAG_C = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_AND  = 4'h2,
      OP_OR   = 4'h3,
      OP_XOR  = 4'h4,
      OP_NOTA = 4'h5,
      OP_SHL  = 4'h6,
      OP_SHR  = 4'h7,
      OP_MUL  = 4'h8,
      OP_INC  = 4'h9,
      OP_DEC  = 4'hA,
      OP_ACSB = 4'hB,
      OP_CMP  = 4'hC,
      OP_LDA  = 4'hD,
      OP_ACAD = 4'hE,
      OP_NOP  = 4'hF
   } opcode_e;

endpackage

// File: rtl/tt_um_processor_alu.sv
// rtl/tt_um_processor_alu.sv - combinational opcode decode and datapath
import tt_um_processor_pkg::*;

module processor_alu (
   input  logic [3:0]       opcode,
   input  logic [OPD_W-1:0] a,
   input  logic [OPD_W-1:0] b,
   input  logic [ACC_W-1:0] acc,
   output logic [ACC_W-1:0] result,
   output logic [3:0]       flags,
   output logic             write_en
);

   logic [ACC_W-1:0] a8;
   logic [ACC_W-1:0] b8;
   logic [4:0]       sum5;
   logic [4:0]       diff5;
   logic [8:0]       acc_sum9;
   logic             c;
   logic             v;

   always_comb begin
      a8       = {4'h0, a};
      b8       = {4'h0, b};
      sum5     = {1'b0, a} + {1'b0, b};
      diff5    = {1'b0, a} - {1'b0, b};
      acc_sum9 = {1'b0, acc} + {1'b0, b8};
      result   = acc;
      c        = 1'b0;
      v        = 1'b0;
      write_en = 1'b1;
      case (opcode_e'(opcode))
         OP_ADD: begin
            result = {3'b000, sum5};
            c      = sum5[4];
            v      = (a[3] == b[3]) && (sum5[3] != a[3]);
         end
         OP_SUB: begin
            result = a8 - b8;
            c      = (a < b);
            v      = (a[3] != b[3]) && (diff5[3] != a[3]);
         end
         OP_AND:  result = a8 & b8;
         OP_OR:   result = a8 | b8;
         OP_XOR:  result = a8 ^ b8;
         OP_NOTA: result = {4'h0, ~a};
         OP_SHL:  result = a8 << b[1:0];
         OP_SHR:  result = a8 >> b[1:0];
         OP_MUL:  result = a8 * b8;
         OP_INC:  result = a8 + 8'd1;
         OP_DEC: begin
            result = a8 - 8'd1;
            c      = (a == 4'h0);
         end
         OP_ACSB: begin
            result = acc - b8;
            c      = (acc < b8);
         end
         OP_CMP: begin
            result = acc;
            c      = (a < b);
         end
         OP_LDA:  result = a8;
         OP_ACAD: begin
            result = acc_sum9[7:0];
            c      = acc_sum9[8];
         end
         default: write_en = 1'b0;
      endcase
      flags         = 4'h0;
      flags[FLAG_C] = c;
      // CMP leaves ACC alone, so its Z reports operand equality instead.
      flags[FLAG_Z] = (opcode_e'(opcode) == OP_CMP) ? (a == b) : (result == 8'h00);
      flags[FLAG_N] = result[7];
      flags[FLAG_V] = v;
   end

endmodule

// File: rtl/tt_um_processor.sv
// rtl/tt_um_processor.sv - TinyTapeout top: accumulator/flag registers and pin mapping
import tt_um_processor_pkg::*;

module tt_um_processor (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic [3:0]       flags_q;
   logic [3:0]       flags_d;
   logic [ACC_W-1:0] alu_result;
   logic [3:0]       alu_flags;
   logic             alu_we;
   logic             unused_uio_hi;

   assign unused_uio_hi = &{1'b0, uio_in[7:4]};

   processor_alu u_alu (
      .opcode   (ui_in[7:4]),
      .a        (ui_in[3:0]),
      .b        (uio_in[3:0]),
      .acc      (acc_q),
      .result   (alu_result),
      .flags    (alu_flags),
      .write_en (alu_we)
   );

   always_comb begin
      acc_d   = acc_q;
      flags_d = flags_q;
      if (ena && alu_we) begin
         acc_d   = alu_result;
         flags_d = alu_flags;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         flags_q <= '0;
      end else begin
         acc_q   <= acc_d;
         flags_q <= flags_d;
      end
   end

   assign uo_out  = acc_q;
   assign uio_out = {flags_q, 4'h0};
   assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_processor.sv
// tb/tb_tt_um_processor.sv - scoreboard bench with randomized ops against an arithmetic model
module tb_tt_um_processor;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int tests;
   int fails;
   int m_acc;
   int m_c, m_z, m_n, m_v;
   logic [15:0] exp_q[$];

   tt_um_processor dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int sx4(input int x);
      return (x > 7) ? x - 16 : x;
   endfunction

   // Reference model: each opcode's rule in plain integer arithmetic.
   task automatic model(input int op, input int a, input int b, input bit en);
      int r, c, v, s;
      if (!en || op == 15) return;
      c = 0;
      v = 0;
      case (op)
         0: begin r = a + b; c = (r >= 16); s = sx4(a) + sx4(b); v = (s > 7 || s < -8); end
         1: begin r = (a - b + 256) % 256; c = (a < b); s = sx4(a) - sx4(b); v = (s > 7 || s < -8); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = 15 - a;
         6: r = a * (1 << (b % 4));
         7: r = a / (1 << (b % 4));
         8: r = a * b;
         9: r = a + 1;
         10: begin r = (a + 255) % 256; c = (a == 0); end
         11: begin r = (m_acc - b + 256) % 256; c = (m_acc < b); end
         12: begin r = m_acc; c = (a < b); end
         13: r = a;
         default: begin r = m_acc + b; c = (r > 255); r = r % 256; end
      endcase
      m_acc = r;
      m_c = c;
      m_v = v;
      m_z = (op == 12) ? (a == b) : (r == 0);
      m_n = (r >= 128);
   endtask

   task automatic issue(input int op, input int a, input int b, input bit en);
      @(negedge clk);
      ena    = en;
      ui_in  = 8'((op << 4) | a);
      uio_in = 8'(($urandom_range(0, 15) << 4) | b);
      model(op, a, b, en);
      exp_q.push_back({8'(m_acc), 4'(m_c * 8 + m_z * 4 + m_n * 2 + m_v), 4'h0});
   endtask

   task automatic model_reset();
      m_acc = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
   endtask

   task automatic async_reset();
      @(posedge clk);
      #3;
      ena   = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async_rst_acc", uo_out, 0);
      check("async_rst_flags", uio_out, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      logic [15:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("acc", uo_out, e[15:8]);
            check("uio_out", uio_out, e[7:0]);
            check("uio_oe", uio_oe, 8'hF0);
         end
      end
   end

   initial begin : stim
      int ab[6][2];
      tests = 0;
      fails = 0;
      model_reset();
      rst_n  = 1'b0;
      ena    = 1'b0;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      #3;
      check("rst_acc", uo_out, 0);
      check("rst_uio_out", uio_out, 0);
      check("rst_uio_oe", uio_oe, 8'hF0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      issue(0, 3, 2, 1'b0);
      issue(9, 7, 0, 1'b0);

      ab = '{'{3, 2}, '{1, 4}, '{5, 3}, '{7, 2}, '{0, 0}, '{1, 1}};
      foreach (ab[i]) issue(0, ab[i][0], ab[i][1], 1'b1);
      issue(0, 15, 15, 1'b1);
      issue(0, 7, 1, 1'b1);
      issue(1, 2, 5, 1'b1);
      issue(1, 8, 1, 1'b1);
      issue(12, 7, 7, 1'b1);
      issue(12, 3, 9, 1'b1);
      issue(13, 9, 0, 1'b1);
      issue(14, 0, 15, 1'b1);
      issue(11, 0, 15, 1'b1);
      issue(13, 15, 0, 1'b1);
      issue(14, 0, 15, 1'b1);
      issue(14, 0, 15, 1'b1);
      issue(14, 0, 15, 1'b1);
      issue(14, 0, 15, 1'b1);
      issue(14, 0, 15, 1'b1);
      issue(14, 0, 15, 1'b1);
      issue(14, 0, 15, 1'b1);
      issue(14, 0, 15, 1'b1);
      issue(14, 0, 15, 1'b1);
      issue(14, 0, 15, 1'b1);
      issue(14, 0, 15, 1'b1);
      issue(14, 0, 15, 1'b1);
      issue(14, 0, 15, 1'b1);
      issue(14, 0, 15, 1'b1);
      issue(14, 0, 15, 1'b1);
      issue(14, 0, 1, 1'b1);
      issue(8, 15, 15, 1'b1);
      issue(6, 3, 2, 1'b1);
      issue(7, 12, 3, 1'b1);
      issue(5, 5, 0, 1'b1);
      issue(10, 0, 0, 1'b1);
      issue(15, 4, 4, 1'b1);
      issue(0, 1, 1, 1'b0);
      async_reset();
      issue(13, 6, 0, 1'b1);

      for (int i = 0; i < 300; i++) begin
         issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 7) != 0);
         if (i == 150) async_reset();
      end

      @(negedge clk);
      ena = 1'b0;
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
